// File: rtl/seq_match_logger.sv
// Logs the bit position of every "10110" detector match into a first-word-fall-through FIFO,
// with a saturating match counter and sticky overflow. Optional irq output: define SEQ_LOG_IRQ_EN.
module seq_match_logger #(
    parameter int DEPTH     = 8,
    parameter int POS_W     = 16,
    parameter int CNT_W     = 16,
    parameter int IRQ_LEVEL = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bit_valid,
    input  logic                     match,
    input  logic                     clr,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [POS_W-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         match_cnt,
    output logic                     overflow
`ifdef SEQ_LOG_IRQ_EN
    ,
    output logic                     irq
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]    FULL_C  = CW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [POS_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_rd_valid;
    logic [POS_W-1:0] r_rd_data;
    logic [POS_W-1:0] r_pos;
    logic [CNT_W-1:0] r_match_cnt;
    logic             r_overflow;

    logic             w_event;
    logic             w_pop;
    logic             w_full;
    logic             w_push;
    logic             w_drop;
    logic [AW-1:0]    w_rptr_nxt;
    logic [CW-1:0]    w_count_nxt;
    logic [POS_W-1:0] w_rd_data_nxt;

    // Push/pop qualification and next occupancy / next head value
    always_comb begin
        w_event       = bit_valid & match;
        w_pop         = r_rd_valid & rd_ready;
        w_full        = (r_count == FULL_C);
        // A full FIFO still accepts a push when the head leaves in the same cycle
        w_push        = w_event & (~w_full | w_pop);
        w_drop        = w_event & w_full & ~w_pop;
        w_rptr_nxt    = r_rptr + AW'(1);
        w_count_nxt   = r_count;
        w_rd_data_nxt = r_rd_data;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
        if (w_pop) begin
            if (r_count > CW'(1)) begin
                w_rd_data_nxt = r_mem[w_rptr_nxt];
            end else if (w_push) begin
                w_rd_data_nxt = r_pos;
            end else begin
                w_rd_data_nxt = r_rd_data;
            end
        end else if (w_push && (r_count == CW'(0))) begin
            w_rd_data_nxt = r_pos;
        end else begin
            w_rd_data_nxt = r_rd_data;
        end
    end

    // Free-running bit position; clr deliberately leaves it alone
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pos <= '0;
        end else if (bit_valid) begin
            r_pos <= r_pos + POS_W'(1);
        end
    end

    // Entry storage; contents only become visible through the pointers below
    always_ff @(posedge clk) begin
        if (w_push && rst && !clr) begin
            r_mem[r_wptr] <= r_pos;
        end
    end

    // FIFO pointers, occupancy and registered head
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= w_rptr_nxt;
            end
            r_count    <= w_count_nxt;
            r_rd_valid <= (w_count_nxt != CW'(0));
            r_rd_data  <= w_rd_data_nxt;
        end
    end

    // Status: saturating match counter and sticky overflow
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            r_match_cnt <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_event && (r_match_cnt != CNT_MAX)) begin
                r_match_cnt <= r_match_cnt + CNT_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign count     = r_count;
    assign match_cnt = r_match_cnt;
    assign overflow  = r_overflow;

`ifdef SEQ_LOG_IRQ_EN
    logic r_irq;

    // Interrupt follows registered occupancy/overflow with one cycle of lag
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (r_count >= CW'(IRQ_LEVEL)) | r_overflow;
        end
    end

    assign irq = r_irq;
`else
    logic w_unused_irq_level;
    assign w_unused_irq_level = (IRQ_LEVEL > 0);
`endif

endmodule

// File: tb/tb_seq_match_logger.sv
// Self-checking bench for seq_match_logger: directed scenarios followed by random traffic,
// all compared against a queue-based reference model.
module tb_seq_match_logger;

    localparam int DEPTH     = 8;
    localparam int POS_W     = 16;
    localparam int CNT_W     = 16;
    localparam int IRQ_LEVEL = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    bit_valid = 1'b0;
    logic                    match = 1'b0;
    logic                    clr = 1'b0;
    logic                    rd_ready = 1'b0;
    logic                    rd_valid;
    logic [POS_W-1:0]        rd_data;
    logic [$clog2(DEPTH):0]  count;
    logic [CNT_W-1:0]        match_cnt;
    logic                    overflow;
`ifdef SEQ_LOG_IRQ_EN
    logic                    irq;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int q[$];
    int m_pos  = 0;
    int m_cnt  = 0;
    int m_last = 0;
    bit m_ov   = 1'b0;
    bit m_irq  = 1'b0;
    logic [4:0] hist = 5'b0;

    seq_match_logger #(
        .DEPTH(DEPTH), .POS_W(POS_W), .CNT_W(CNT_W), .IRQ_LEVEL(IRQ_LEVEL)
    ) dut (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .match(match), .clr(clr),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .count(count),
        .match_cnt(match_cnt), .overflow(overflow)
`ifdef SEQ_LOG_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit bv, input bit m, input bit rdy, input bit c, input bit r);
        bit nxt_irq;
        if (!r) begin
            q.delete();
            m_pos = 0; m_cnt = 0; m_last = 0; m_ov = 1'b0; m_irq = 1'b0;
        end else begin
            nxt_irq = c ? 1'b0 : ((q.size() >= IRQ_LEVEL) || m_ov);
            if (c) begin
                q.delete();
                m_cnt = 0; m_ov = 1'b0; m_last = 0;
            end else begin
                if ((q.size() != 0) && rdy) void'(q.pop_front());
                if (bv && m) begin
                    if (m_cnt < CNT_MAX) m_cnt++;
                    if (q.size() < DEPTH) q.push_back(m_pos);
                    else m_ov = 1'b1;
                end
                if (q.size() != 0) m_last = q[0];
            end
            if (bv) m_pos = (m_pos + 1) % (1 << POS_W);
            m_irq = nxt_irq;
        end
    endtask

    task automatic check_all();
        chk("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
        chk("count", 32'(count), 32'(q.size()));
        chk("rd_data", 32'(rd_data), 32'(m_last));
        chk("match_cnt", 32'(match_cnt), 32'(m_cnt));
        chk("overflow", 32'(overflow), 32'(m_ov));
`ifdef SEQ_LOG_IRQ_EN
        chk("irq", 32'(irq), 32'(m_irq));
`endif
    endtask

    task automatic step(input bit bv, input bit m, input bit rdy, input bit c, input bit r);
        @(negedge clk);
        bit_valid = bv; match = m; rd_ready = rdy; clr = c; rst = r;
        @(posedge clk);
        model(bv, m, rdy, c, r);
        #1;
        check_all();
    endtask

    // feed one serial bit; the match flag comes from a 5-bit history compare
    task automatic send_bit(input bit x, input bit rdy);
        logic [4:0] h;
        h = {hist[3:0], x};
        hist = h;
        step(1'b1, (h == 5'b10110), rdy, 1'b0, 1'b1);
    endtask

    initial begin
        bit b0, b1, b2, b3, b4;
        logic [7:0] stream;
        stream = 8'b0110_1101;  // LSB first: 1,0,1,1,0,1,1,0

        // reset held two cycles
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);

        // detector stream, matches complete at indices 4 and 7
        for (int i = 0; i < 8; i++) send_bit(stream[i], 1'b0);
        chk("tp1_count", 32'(count), 32'd2);
        chk("tp1_match_cnt", 32'(match_cnt), 32'd2);
        chk("tp1_rd_valid", 32'(rd_valid), 32'd1);
        chk("tp1_rd_data", 32'(rd_data), 32'd4);

        // drain both entries
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("tp2_second", 32'(rd_data), 32'd7);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("tp2_empty_valid", 32'(rd_valid), 32'd0);
        chk("tp2_empty_count", 32'(count), 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // overflow: 9 matches into 8 entries
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("tp3_count", 32'(count), 32'd8);
        chk("tp3_overflow", 32'(overflow), 32'd1);
        chk("tp3_match_cnt", 32'(match_cnt), 32'd9);
        chk("tp3_head", 32'(rd_data), 32'd8);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // full FIFO with simultaneous pop and match at pos 20
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        while (m_pos != 20) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("tp4_count", 32'(count), 32'd8);
        chk("tp4_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("tp4_last", 32'(rd_data), 32'd20);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // clr with concurrent match, then reset mid-stream
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("tp5_clr_count", 32'(count), 32'd0);
        chk("tp5_clr_cnt", 32'(match_cnt), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("tp5_pos_kept", 32'(rd_data), 32'd23);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("tp5_rst_valid", 32'(rd_valid), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("tp5_pos_reset", 32'(rd_data), 32'd1);

`ifdef SEQ_LOG_IRQ_EN
        // irq threshold behaviour
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("irq_at3", 32'(irq), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("irq_lag", 32'(irq), 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("irq_at4", 32'(irq), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("irq_drop", 32'(irq), 32'd0);
`endif

        // random traffic in phases of differing reader speed
        for (int i = 0; i < 600; i++) begin
            b0 = ($urandom_range(0, 3) != 0);
            b1 = ($urandom_range(0, 2) == 0);
            b2 = (i % 200 < 100) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 1);
            b3 = ($urandom_range(0, 59) == 0);
            b4 = ($urandom_range(0, 149) != 0);
            step(b0, b1, b2, b3, b4);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_match_logger.md
Name: seq_match_logger

Overview:
- Downstream consumer of the Mealy "10110" sequence detector.
- Samples the detector's serial input and its match output on every valid bit, and keeps a free-running bit-position counter.
- On each match, logs the position of the completing bit into a small FIFO; a reader drains the FIFO over a valid/ready handshake.
- Also keeps a saturating total-match counter and a sticky overflow flag for status readback.

Parameters:
- DEPTH, 8: FIFO entries; power of two, minimum 2.
- POS_W, 16: width of the bit-position counter and of each FIFO entry.
- CNT_W, 16: width of the total-match counter.
- IRQ_LEVEL, 4: FIFO occupancy threshold for irq; used only with the optional feature; range 1..DEPTH.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low; 0 clears all state on the next rising clk edge.
- bit_valid  in  1  a detector input bit X is presented this cycle.
- match  in  1  detector output Y; combinational (Mealy) with the same-cycle X; qualified by bit_valid.
- clr  in  1  synchronous soft clear of the log and status.
- rd_valid  out  1  FIFO non-empty.
- rd_ready  in  1  reader accepts the head entry.
- rd_data  out  POS_W  position of the oldest logged match (first-word fall-through).
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- match_cnt  out  CNT_W  total matches seen since reset/clr, saturating.
- overflow  out  1  sticky; a match was dropped because the FIFO was full.
- irq  out  1  present only with SEQ_LOG_IRQ_EN.

Behaviour:
- Reset (rst=0 at clk edge): pos=0, FIFO empty, count=0, rd_valid=0, rd_data=0, match_cnt=0, overflow=0, irq=0.
- Priority: rst > clr > normal operation.
- Position counter pos (POS_W bits):
  - Increments by 1 on every cycle with bit_valid=1; wraps from all-ones to 0.
  - Not affected by clr.
  - The value logged for a match is pos before the increment, i.e. the index of the bit that completed the sequence.
- Push: match=1 and bit_valid=1 is a match event. match with bit_valid=0 is ignored.
- Match event, FIFO not full, or full with a pop in the same cycle:
  - entry written, count updated net of any pop.
- Match event, FIFO full and no pop:
  - entry dropped, overflow set to 1.
- Pop: rd_valid=1 and rd_ready=1 removes the head.
  - rd_data shows the next entry in the following cycle; rd_valid=0 if the FIFO is then empty.
  - rd_ready with rd_valid=0 has no effect.
- Simultaneous push and pop:
  - FIFO non-empty: count unchanged.
  - FIFO empty: push only, no pop; rd_valid goes 1 next cycle.
- Latency: a match event at edge N makes the entry visible at rd_data/rd_valid after edge N (one cycle); no combinational path from match to rd_valid.
- match_cnt:
  - Increments on every match event, including dropped ones.
  - Holds at 2^CNT_W-1.
- clr=1: FIFO emptied, count=0, match_cnt=0, overflow=0. Any match event and pop in that same cycle are discarded.
- Pointer wrap: read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty is derived from count.
- rd_data while rd_valid=0: holds its last value (0 after reset/clr); it is not meaningful.

Optional Feature:
- Macro: SEQ_LOG_IRQ_EN.
- Defined:
  - Adds registered output irq = (count >= IRQ_LEVEL) OR overflow, updated one cycle after count/overflow change.
  - Cleared by rst and clr.
- Undefined: irq port and its logic are absent; IRQ_LEVEL is unused. All other behaviour is identical.

Test Plan:
- Release rst after 2 cycles; drive bit_valid=1 with stream 1,0,1,1,0,1,1,0 and detector match at indices 4 and 7 -> FIFO holds 4 then 7, count=2, match_cnt=2, rd_valid=1, rd_data=4.
- With 2 entries logged, hold rd_ready=1 -> rd_data=4 then 7 on consecutive cycles, then rd_valid=0, count=0.
- With rd_ready=0, generate 9 match events at DEPTH=8 -> count=8, overflow=1, match_cnt=9, entries are the first 8 positions in order.
- FIFO full and rd_ready=1 at the same cycle as a match at pos=20 -> count stays 8, overflow stays 0, last entry=20.
- Pulse clr concurrent with a match, then pulse rst=0 mid-stream -> after clr: count=0, match_cnt=0, overflow=0, pos still counting; after rst: pos=0 and all outputs 0.
- With SEQ_LOG_IRQ_EN and IRQ_LEVEL=4, log 3 then 4 matches -> irq=0 at 3, irq=1 one cycle after count reaches 4; pop one -> irq=0 one cycle later.
